// File: rtl/piece_queue_manager.sv
// piece_queue_manager: falling piece, PREVIEW_DEPTH-deep upcoming-piece queue
// and optional hold slot, filled from the LFSR random streams.
// Optional feature macro: TETRIS_HOLD_EN (hold slot, hold lock, hold_req logic).
//
// state | meaning
// IDLE  | after reset; values held, only init_req acts
// FILL  | chain shifts in random pieces every cycle, D+1 shifts total
// READY | queue full; spawn / hold / rotate requests accepted
module piece_queue_manager #(
  parameter int PREVIEW_DEPTH = 3,
  parameter int TYPE_W        = 3,
  parameter int NUM_TYPES     = 7,
  parameter int ROT_W         = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              init_req,
  input  logic                              spawn_req,
  input  logic                              rot_load,
  input  logic [ROT_W-1:0]                  rot_value,
  input  logic                              hold_req,
  input  logic [TYPE_W-1:0]                 rand_type,
  input  logic [ROT_W-1:0]                  rand_rot,
  output logic [TYPE_W-1:0]                 current_block_type,
  output logic [ROT_W-1:0]                  current_block_rotation,
  output logic [TYPE_W-1:0]                 next_block_type,
  output logic [ROT_W-1:0]                  next_block_rotation,
  output logic [PREVIEW_DEPTH*TYPE_W-1:0]   preview_types,
  output logic [PREVIEW_DEPTH*ROT_W-1:0]    preview_rots,
  output logic [TYPE_W-1:0]                 hold_type,
  output logic                              hold_valid,
  output logic                              ready
);

  localparam int FCW = $clog2(PREVIEW_DEPTH + 2);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam logic [TYPE_W:0]   NT_EXT = (TYPE_W + 1)'(NUM_TYPES);
  localparam logic [TYPE_W-1:0] NT_LO  = TYPE_W'(NUM_TYPES);

  logic [1:0]        state;
  logic [FCW-1:0]    fill_cnt;
  logic [TYPE_W-1:0] q_type [PREVIEW_DEPTH];
  logic [ROT_W-1:0]  q_rot  [PREVIEW_DEPTH];
  logic [TYPE_W-1:0] cur_type;
  logic [ROT_W-1:0]  cur_rot;
  logic [TYPE_W-1:0] rand_fold;

  logic              hold_ok;
  logic              hold_v_r;
  logic [TYPE_W-1:0] hold_t_r;
  logic              in_ready, spawn_go, hold_go, hold_take, hold_swap, rot_go, shift;

  // Fold out-of-range random types back into 0..NUM_TYPES-1 (one subtraction suffices).
  assign rand_fold = ({1'b0, rand_type} >= NT_EXT) ? (rand_type - NT_LO) : rand_type;

`ifdef TETRIS_HOLD_EN
  logic hold_lock;
  assign hold_ok = hold_req && !hold_lock;

  // Hold slot and lock: init clears, a spawn re-arms, an accepted hold stores current type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_t_r  <= '0;
      hold_v_r  <= 1'b0;
      hold_lock <= 1'b0;
    end else if (init_req) begin
      hold_t_r  <= '0;
      hold_v_r  <= 1'b0;
      hold_lock <= 1'b0;
    end else if (spawn_go) begin
      hold_lock <= 1'b0;
    end else if (hold_go) begin
      hold_t_r  <= cur_type;
      hold_v_r  <= 1'b1;
      hold_lock <= 1'b1;
    end
  end
`else
  logic unused_hold_req;
  assign unused_hold_req = hold_req;
  assign hold_ok  = 1'b0;
  assign hold_v_r = 1'b0;
  assign hold_t_r = '0;
`endif

  // Request decode: init beats everything, then spawn > hold > rotate in READY.
  always_comb begin
    in_ready  = (state == READY) && !init_req;
    spawn_go  = in_ready && spawn_req;
    hold_go   = in_ready && !spawn_req && hold_ok;
    hold_take = hold_go && !hold_v_r;
    hold_swap = hold_go && hold_v_r;
    rot_go    = in_ready && !spawn_req && !hold_go && rot_load;
    shift     = ((state == FILL) && !init_req) || spawn_go || hold_take;
  end

  // Sequencer: init restarts the fill count; D+1 shifts bring the queue to READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fill_cnt <= '0;
    end else if (init_req) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == FCW'(PREVIEW_DEPTH)) state <= READY;
        end
        default: state <= state;
      endcase
    end
  end

  // Piece chain: shift current <- q[0] <- ... <- random tail, or swap/rotate current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_type <= '0;
      cur_rot  <= '0;
      for (int i = 0; i < PREVIEW_DEPTH; i++) begin
        q_type[i] <= '0;
        q_rot[i]  <= '0;
      end
    end else if (shift) begin
      cur_type <= q_type[0];
      cur_rot  <= hold_take ? '0 : q_rot[0];
      for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
        q_type[i] <= q_type[i+1];
        q_rot[i]  <= q_rot[i+1];
      end
      q_type[PREVIEW_DEPTH-1] <= rand_fold;
      q_rot[PREVIEW_DEPTH-1]  <= rand_rot;
    end else if (hold_swap) begin
      cur_type <= hold_t_r;
      cur_rot  <= '0;
    end else if (rot_go) begin
      cur_rot <= rot_value;
    end
  end

  // Pack the queue for the preview display.
  always_comb begin
    preview_types = '0;
    preview_rots  = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      preview_types[i*TYPE_W +: TYPE_W] = q_type[i];
      preview_rots[i*ROT_W +: ROT_W]    = q_rot[i];
    end
  end

  assign current_block_type     = cur_type;
  assign current_block_rotation = cur_rot;
  assign next_block_type        = q_type[0];
  assign next_block_rotation    = q_rot[0];
  assign hold_type              = hold_t_r;
  assign hold_valid             = hold_v_r;
  assign ready                  = (state == READY);

endmodule

// File: tb/tb_piece_queue_manager.sv
// Directed bench for piece_queue_manager (default parameters, D=3).
// Hold checks follow TETRIS_HOLD_EN as compiled.
module tb_piece_queue_manager;
  logic       clk = 1'b0;
  logic       rst, init_req, spawn_req, rot_load, hold_req;
  logic [1:0] rot_value, rand_rot;
  logic [2:0] rand_type;
  logic [2:0] cur_t, next_t, hold_t;
  logic [1:0] cur_r, next_r;
  logic [8:0] prev_t;
  logic [5:0] prev_r;
  logic       hold_v, rdy;
  int checks = 0;
  int failures = 0;

  piece_queue_manager dut (
    .clk(clk), .rst(rst), .init_req(init_req), .spawn_req(spawn_req),
    .rot_load(rot_load), .rot_value(rot_value), .hold_req(hold_req),
    .rand_type(rand_type), .rand_rot(rand_rot),
    .current_block_type(cur_t), .current_block_rotation(cur_r),
    .next_block_type(next_t), .next_block_rotation(next_r),
    .preview_types(prev_t), .preview_rots(prev_r),
    .hold_type(hold_t), .hold_valid(hold_v), .ready(rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [2:0] t, input logic [1:0] r);
    rand_type = t;
    rand_rot  = r;
    tick();
  endtask

  task automatic check_piece(input string tag, input logic [2:0] ct, input logic [1:0] cr,
                             input logic [8:0] pt, input logic [5:0] pr);
    check({tag, "_cur_type"}, 32'(cur_t), 32'(ct));
    check({tag, "_cur_rot"}, 32'(cur_r), 32'(cr));
    check({tag, "_next_type"}, 32'(next_t), 32'(pt[2:0]));
    check({tag, "_next_rot"}, 32'(next_r), 32'(pr[1:0]));
    check({tag, "_prev_types"}, 32'(prev_t), 32'(pt));
    check({tag, "_prev_rots"}, 32'(prev_r), 32'(pr));
  endtask

  initial begin
    rst = 1'b1; init_req = 0; spawn_req = 0; rot_load = 0; hold_req = 0;
    rot_value = 0; rand_type = 0; rand_rot = 0;
    tick(); tick();
    check_piece("reset", 3'd0, 2'd0, 9'd0, 6'd0);
    check("reset_ready", 32'(rdy), 32'd0);
    check("reset_hold_valid", 32'(hold_v), 32'd0);
    check("reset_hold_type", 32'(hold_t), 32'd0);
    rst = 1'b0;
    tick();

    // spawn in IDLE is ignored
    spawn_req = 1; rand_type = 3'd5; tick(); spawn_req = 0;
    check_piece("idle_spawn", 3'd0, 2'd0, 9'd0, 6'd0);
    check("idle_ready", 32'(rdy), 32'd0);

    // init fill 1,2,3,4 / 0,1,2,3
    init_req = 1; tick(); init_req = 0;
    check("fill_ready0", 32'(rdy), 32'd0);
    shift_in(3'd1, 2'd0);
    shift_in(3'd2, 2'd1);
    shift_in(3'd3, 2'd2);
    check("fill_ready3", 32'(rdy), 32'd0);
    shift_in(3'd4, 2'd3);
    check("fill_ready4", 32'(rdy), 32'd1);
    check_piece("fill", 3'd1, 2'd0, {3'd4, 3'd3, 3'd2}, {2'd3, 2'd2, 2'd1});

    // spawn with rand 5/0
    spawn_req = 1; shift_in(3'd5, 2'd0); spawn_req = 0;
    check_piece("spawn1", 3'd2, 2'd1, {3'd5, 3'd4, 3'd3}, {2'd0, 2'd3, 2'd2});
    check("spawn1_ready", 32'(rdy), 32'd1);

    // spawn + rot_load together: spawn wins
    spawn_req = 1; rot_load = 1; rot_value = 2'd3;
    shift_in(3'd6, 2'd1);
    spawn_req = 0; rot_load = 0;
    check_piece("spawn_rot", 3'd3, 2'd2, {3'd6, 3'd5, 3'd4}, {2'd1, 2'd0, 2'd3});

    // lone rotate
    rot_load = 1; rot_value = 2'd1; shift_in(3'd2, 2'd2); rot_load = 0;
    check_piece("rotate", 3'd3, 2'd1, {3'd6, 3'd5, 3'd4}, {2'd1, 2'd0, 2'd3});

    // re-init: no shift on the init edge, fold of 7 during fill, then reset mid-FILL
    init_req = 1; tick(); init_req = 0;
    check("reinit_ready", 32'(rdy), 32'd0);
    check("reinit_cur", 32'(cur_t), 32'd3);
    shift_in(3'd7, 2'd2);
    check_piece("fold1", 3'd4, 2'd3, {3'd0, 3'd6, 3'd5}, {2'd2, 2'd1, 2'd0});
    shift_in(3'd2, 2'd0);
    check_piece("fold2", 3'd5, 2'd0, {3'd2, 3'd0, 3'd6}, {2'd0, 2'd2, 2'd1});
    #1 rst = 1'b1;
    #1;
    check_piece("async_rst", 3'd0, 2'd0, 9'd0, 6'd0);
    check("async_rst_ready", 32'(rdy), 32'd0);
    tick();
    rst = 1'b0;
    spawn_req = 1; tick(); spawn_req = 0;
    check_piece("rst_idle_spawn", 3'd0, 2'd0, 9'd0, 6'd0);
    check("rst_idle_ready", 32'(rdy), 32'd0);

    // init, one shift, init again (restart), then full fill
    init_req = 1; tick(); init_req = 0;
    shift_in(3'd6, 2'd3);
    init_req = 1; tick(); init_req = 0;
    shift_in(3'd1, 2'd0);
    shift_in(3'd2, 2'd1);
    shift_in(3'd3, 2'd2);
    check("restart_ready3", 32'(rdy), 32'd0);
    shift_in(3'd4, 2'd3);
    check("restart_ready4", 32'(rdy), 32'd1);
    check_piece("restart", 3'd1, 2'd0, {3'd4, 3'd3, 3'd2}, {2'd3, 2'd2, 2'd1});

`ifdef TETRIS_HOLD_EN
    hold_req = 1; shift_in(3'd6, 2'd2); hold_req = 0;
    check_piece("hold1", 3'd2, 2'd0, {3'd6, 3'd4, 3'd3}, {2'd2, 2'd3, 2'd2});
    check("hold1_type", 32'(hold_t), 32'd1);
    check("hold1_valid", 32'(hold_v), 32'd1);
    hold_req = 1; shift_in(3'd5, 2'd1); hold_req = 0;
    check_piece("hold_locked", 3'd2, 2'd0, {3'd6, 3'd4, 3'd3}, {2'd2, 2'd3, 2'd2});
    check("hold_locked_type", 32'(hold_t), 32'd1);
    spawn_req = 1; shift_in(3'd5, 2'd1); spawn_req = 0;
    check_piece("hold_spawn", 3'd3, 2'd2, {3'd5, 3'd6, 3'd4}, {2'd1, 2'd2, 2'd3});
    hold_req = 1; shift_in(3'd0, 2'd0); hold_req = 0;
    check_piece("hold_swap", 3'd1, 2'd0, {3'd5, 3'd6, 3'd4}, {2'd1, 2'd2, 2'd3});
    check("hold_swap_type", 32'(hold_t), 32'd3);
    check("hold_swap_valid", 32'(hold_v), 32'd1);
`else
    hold_req = 1; shift_in(3'd6, 2'd2); hold_req = 0;
    tick();
    hold_req = 1; shift_in(3'd5, 2'd1); hold_req = 0;
    check_piece("nohold", 3'd1, 2'd0, {3'd4, 3'd3, 3'd2}, {2'd3, 2'd2, 2'd1});
    check("nohold_valid", 32'(hold_v), 32'd0);
    check("nohold_type", 32'(hold_t), 32'd0);
`endif
    check("final_ready", 32'(rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piece_queue_manager.md
# piece_queue_manager

Parametrised successor to the two-slot current/next piece register. Keeps the falling piece, a PREVIEW_DEPTH-deep queue of upcoming pieces, and an optional hold slot. Fills the queue from the LFSR random streams and advances it on a spawn handshake from the game FSM. Drives the playfield renderer, collision logic and the preview/hold display.

## Interface
Parameters:
- PREVIEW_DEPTH, 3: upcoming pieces queued (q[0] = next); legal range 1..6.
- TYPE_W, 3: piece-type width.
- NUM_TYPES, 7: legal types are 0..NUM_TYPES-1; requires NUM_TYPES ≤ 2^TYPE_W < 2*NUM_TYPES.
- ROT_W, 2: rotation width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_req  in  1  pulse; (re)start the queue fill, clear the hold slot.
- spawn_req  in  1  pulse; retire current, advance the queue.
- rot_load  in  1  load rot_value into current rotation.
- rot_value  in  ROT_W  rotation from the rotate unit.
- hold_req  in  1  pulse; hold/swap current (TETRIS_HOLD_EN only; ignored otherwise).
- rand_type  in  TYPE_W  random type, sampled each cycle a slot is refilled.
- rand_rot  in  ROT_W  random rotation, sampled with rand_type.
- current_block_type  out  TYPE_W  falling piece type.
- current_block_rotation  out  ROT_W  falling piece rotation.
- next_block_type  out  TYPE_W  q[0] type.
- next_block_rotation  out  ROT_W  q[0] rotation.
- preview_types  out  PREVIEW_DEPTH*TYPE_W  q[i] at bits [i*TYPE_W +: TYPE_W].
- preview_rots  out  PREVIEW_DEPTH*ROT_W  q[i] rotation, same packing.
- hold_type  out  TYPE_W  held type (0 when empty or feature off).
- hold_valid  out  1  hold slot occupied.
- ready  out  1  queue full; spawn/rotate/hold accepted.

## Operation
- FSM states: IDLE, FILL, READY. Reset -> IDLE. All outputs reset to 0; the hold slot is empty and the hold lock is clear.
- Type folding: a sampled type t becomes t - NUM_TYPES when t ≥ NUM_TYPES, otherwise t.
- Any state, init_req=1 -> FILL, fill_cnt=0, hold cleared, hold lock cleared. init_req has priority over all other requests.
- FILL: every cycle the chain shifts: current <- q[0] <- ... <- q[D-1] <- {fold(rand_type), rand_rot}. fill_cnt increments. After D+1 shifts, the state goes to READY. spawn/rot/hold requests are ignored.
- READY priority: spawn_req > hold_req > rot_load. Lower-priority requests in the same cycle are dropped.
- Spawn: the chain shifts one position and the tail is loaded from the random inputs. The hold lock is cleared.
- Rotate: current_block_rotation <= rot_value. The type is unchanged.
- Hold (macro on, lock clear):
  - Hold empty: hold <= current type, current <= q[0], and the queue shifts as in a spawn.
  - Hold full: current type and hold type swap.
  - Either case: the incoming current rotation is 0 and the lock is set.
  - hold_req with the lock set is ignored.
- IDLE: holds all values; only init_req acts.

## Timing
- All requests are sampled on the rising clk edge. Outputs update on that same edge and are visible the next cycle (1-cycle latency).
- An init_req at edge N gives shifts at edges N+1..N+D+1. ready rises after edge N+D+1 (D=3: 4 cycles).
- ready is 0 in IDLE and FILL, and 1 only in READY. A spawn in READY does not drop ready.
- An init_req during FILL restarts the count. Partially filled entries are overwritten.
- rst asserted mid-FILL or mid-operation: immediate return to IDLE with all outputs 0.
- fill_cnt width is clog2(PREVIEW_DEPTH+2). It never wraps.

## Configuration
- TETRIS_HOLD_EN defined: the hold slot, hold lock, hold_req logic and the hold_type/hold_valid drivers are compiled in.
- Undefined: hold_req is ignored, and hold_type/hold_valid are tied to 0. The port list is unchanged.

## Test plan
- Init fill (D=3): rand_type 1,2,3,4 and rand_rot 0,1,2,3 on successive FILL cycles -> current=1/rot0, next=2/rot1, preview_types=[2,3,4], ready=1 exactly 4 cycles after init_req.
- Fold: rand_type=7 during fill (NUM_TYPES=7) -> that slot holds 0. A spawn with rand_type=5 -> current=2, preview=[3,4,5].
- Simultaneous spawn_req+rot_load rot_value=3 -> spawn taken, current rotation is the queued value (not 3). A lone rot_load of 2 next cycle -> rotation=2.
- Hold (macro on), starting from current=1:
  - hold_req with hold empty -> hold_type=1, hold_valid=1, current=2/rot0, queue shifted.
  - Second hold_req before a spawn -> no change.
  - After a spawn, hold_req -> swap.
- Reset mid-FILL (rst after 2 shifts) -> all outputs 0 and ready=0 next cycle. spawn_req in IDLE -> no change. init_req -> normal fill.
- Macro off: hold_req pulses in READY -> hold_valid stays 0 and current is unchanged.
